// File: rtl/mem_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_unit
// Purpose  : MIPS MEM stage with a multi-cycle internal data memory, a pipeline
//            stall and registered MEM/WB outputs.
// Revision : 1.0  initial release
// ============================================================================
module mem_stage_unit #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] aluResultMEM,
    input  logic [31:0] regReadData2MEM,
    input  logic [4:0]  instructionMEM,
    input  logic        memReadMEM,
    input  logic        memWriteMEM,
    input  logic        memtoRegMEM,
    input  logic        regWriteMEM,
    output logic        stallMEM,
    output logic        alignErrMEM,
    output logic [31:0] memReadDataWB,
    output logic [31:0] aluResultWB,
    output logic [4:0]  instructionWB,
    output logic        memtoRegWB,
    output logic        regWriteWB
);

    localparam int               AW      = $clog2(DEPTH);
    localparam int               CNT_W   = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(LATENCY - 1);
    localparam logic             C_MULTI = (LATENCY > 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      r_mem [DEPTH];

    logic [31:0] r_rd_data;
    logic [31:0] r_alu;
    logic [4:0]  r_instr;
    logic        r_mem_to_reg;
    logic        r_reg_write;

    logic [AW-1:0] w_idx;
    logic          w_req;
    logic          w_aligned;
    logic          w_access;
    logic          w_commit;
    logic          w_pass;
    logic          w_stall;
    logic          w_we;
    logic [31:0]   w_rdata;
    logic          w_unused_addr;

    // Upper address bits are deliberately dropped so accesses wrap modulo DEPTH.
    assign w_idx         = aluResultMEM[AW+1:2];
    assign w_unused_addr = ^{aluResultMEM[31:AW+2]};
    assign w_req         = memReadMEM | memWriteMEM;
    assign w_aligned     = (aluResultMEM[1:0] == 2'b00);
    assign w_access      = w_req & w_aligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        w_pass      = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (C_MULTI) begin
                        w_stall     = 1'b1;
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_commit = 1'b1;
                        w_pass   = 1'b1;
                    end
                end else if (!w_req) begin
                    w_pass = 1'b1;
                end
            end
            S_WAIT: begin
                // Inputs are frozen upstream, so the held request is committed as-is.
                if (r_cnt == C_LAST) begin
                    w_commit    = 1'b1;
                    w_pass      = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign stallMEM    = w_stall & rst_n;
    assign alignErrMEM = w_req & ~w_aligned & rst_n;

    assign w_we    = w_commit & memWriteMEM & rst_n;
    assign w_rdata = (w_commit & memReadMEM & ~memWriteMEM) ? r_mem[w_idx] : 32'h0;

    // Array has no reset: contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_idx] <= regReadData2MEM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data    <= '0;
            r_alu        <= '0;
            r_instr      <= '0;
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
        end else if (w_pass) begin
            r_rd_data    <= w_rdata;
            r_alu        <= aluResultMEM;
            r_instr      <= instructionMEM;
            r_mem_to_reg <= memtoRegMEM;
            r_reg_write  <= regWriteMEM;
        end else begin
            r_rd_data    <= '0;
            r_alu        <= '0;
            r_instr      <= '0;
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
        end
    end

    assign memReadDataWB = r_rd_data;
    assign aluResultWB   = r_alu;
    assign instructionWB = r_instr;
    assign memtoRegWB    = r_mem_to_reg;
    assign regWriteWB    = r_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_unit
// Purpose  : Directed self-checking bench; four instances with LATENCY 1..4.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  ins;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;

    logic        stall [4];
    logic        aerr  [4];
    logic [31:0] rdw   [4];
    logic [31:0] aluw  [4];
    logic [4:0]  insw  [4];
    logic        m2rw  [4];
    logic        rww   [4];

    int errors = 0;
    int checks = 0;

    // Instance k has LATENCY = k+1.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            mem_stage_unit #(
                .DEPTH   (256),
                .LATENCY (gi + 1)
            ) u_dut (
                .clk             (clk),
                .rst_n           (rst_n),
                .aluResultMEM    (alu),
                .regReadData2MEM (wd),
                .instructionMEM  (ins),
                .memReadMEM      (mr),
                .memWriteMEM     (mw),
                .memtoRegMEM     (m2r),
                .regWriteMEM     (rw),
                .stallMEM        (stall[gi]),
                .alignErrMEM     (aerr[gi]),
                .memReadDataWB   (rdw[gi]),
                .aluResultWB     (aluw[gi]),
                .instructionWB   (insw[gi]),
                .memtoRegWB      (m2rw[gi]),
                .regWriteWB      (rww[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic r,
                         input logic w, input logic [4:0] i, input logic t, input logic g);
        alu = a; wd = d; mr = r; mw = w; ins = i; m2r = t; rw = g;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(32'h10, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        checks++; if (stall[1] !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0h expected 0", stall[1]); end
        checks++; if (aluw[1] !== 32'h0) begin errors++; $display("FAIL rst_alu: got %h expected 0", aluw[1]); end
        checks++; if (rww[1] !== 1'b0) begin errors++; $display("FAIL rst_rw: got %0h expected 0", rww[1]); end
        rst_n = 1'b1;
        drive(32'hBEEF, 32'h0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
        step();
        checks++; if (aluw[1] !== 32'hBEEF) begin errors++; $display("FAIL pre_async_alu: got %h expected 0000beef", aluw[1]); end
        rst_n = 1'b0;
        #1;
        checks++; if ({aluw[1], insw[1], m2rw[1], rww[1]} !== 39'h0) begin
            errors++; $display("FAIL async_rst_wb: got alu=%h ins=%0d m2r=%0h rw=%0h expected all 0", aluw[1], insw[1], m2rw[1], rww[1]);
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_alu_op();
        do_reset();
        drive(32'h1234, 32'h0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1);
        checks++; if (stall[1] !== 1'b0) begin errors++; $display("FAIL alu_stall: got %0h expected 0", stall[1]); end
        step();
        checks++; if (aluw[1] !== 32'h1234) begin errors++; $display("FAIL alu_result: got %h expected 00001234", aluw[1]); end
        checks++; if (insw[1] !== 5'd8) begin errors++; $display("FAIL alu_instr: got %0d expected 8", insw[1]); end
        checks++; if (rww[1] !== 1'b1 || m2rw[1] !== 1'b0) begin errors++; $display("FAIL alu_ctrl: got rw=%0h m2r=%0h expected rw=1 m2r=0", rww[1], m2rw[1]); end
        checks++; if (rdw[1] !== 32'h0 || stall[1] !== 1'b0) begin errors++; $display("FAIL alu_rd: got rd=%h stall=%0h expected 0 0", rdw[1], stall[1]); end
    endtask

    task automatic test_store_load();
        do_reset();
        drive(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        checks++; if (stall[1] !== 1'b1) begin errors++; $display("FAIL st_stall0: got %0h expected 1", stall[1]); end
        step();
        checks++; if (stall[1] !== 1'b0) begin errors++; $display("FAIL st_stall1: got %0h expected 0", stall[1]); end
        step();
        checks++; if (aluw[1] !== 32'h10) begin errors++; $display("FAIL st_commit_alu: got %h expected 00000010", aluw[1]); end
        drive(32'h10, 32'h0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
        checks++; if (stall[1] !== 1'b1) begin errors++; $display("FAIL ld_stall0: got %0h expected 1", stall[1]); end
        step();
        checks++; if (rww[1] !== 1'b0 || insw[1] !== 5'd0) begin errors++; $display("FAIL ld_bubble: got rw=%0h ins=%0d expected 0 0", rww[1], insw[1]); end
        step();
        checks++; if (rdw[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_data: got %h expected deadbeef", rdw[1]); end
        checks++; if (insw[1] !== 5'd9 || rww[1] !== 1'b1 || m2rw[1] !== 1'b1) begin
            errors++; $display("FAIL ld_ctrl: got ins=%0d rw=%0h m2r=%0h expected 9 1 1", insw[1], rww[1], m2rw[1]);
        end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        checks++; if (rdw[1] !== 32'h0) begin errors++; $display("FAIL idle_rd: got %h expected 0", rdw[1]); end
    endtask

    task automatic test_latency1();
        do_reset();
        drive(32'h8, 32'h55, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1);
        checks++; if (stall[0] !== 1'b0) begin errors++; $display("FAIL l1_stall: got %0h expected 0", stall[0]); end
        step();
        checks++; if (rdw[0] !== 32'h0 || aluw[0] !== 32'h8) begin errors++; $display("FAIL l1_rdwr: got rd=%h alu=%h expected 0 8", rdw[0], aluw[0]); end
        drive(32'h8, 32'h0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
        step();
        checks++; if (rdw[0] !== 32'h55) begin errors++; $display("FAIL l1_load: got %h expected 00000055", rdw[0]); end
    endtask

    task automatic test_latency4();
        logic exp_s;
        do_reset();
        drive(32'h10, 32'hCAFEF00D, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        repeat (4) step();
        drive(32'h10, 32'h0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            exp_s = (k < 3);
            checks++; if (stall[3] !== exp_s) begin errors++; $display("FAIL l4_stall[%0d]: got %0h expected %0h", k, stall[3], exp_s); end
            step();
            if (k < 3) begin
                checks++; if ({rdw[3], aluw[3], insw[3], m2rw[3], rww[3]} !== 71'h0) begin
                    errors++; $display("FAIL l4_bubble[%0d]: got rd=%h alu=%h ins=%0d rw=%0h expected all 0", k, rdw[3], aluw[3], insw[3], rww[3]);
                end
            end
        end
        checks++; if (rdw[3] !== 32'hCAFEF00D || insw[3] !== 5'd12) begin
            errors++; $display("FAIL l4_data: got rd=%h ins=%0d expected cafef00d 12", rdw[3], insw[3]);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        drive(32'h400, 32'h11223344, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        step(); step();
        drive(32'h404, 32'h55667788, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        step(); step();
        drive(32'h13, 32'h0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
        checks++; if (aerr[1] !== 1'b1 || stall[1] !== 1'b0) begin errors++; $display("FAIL mis_ld_flags: got aerr=%0h stall=%0h expected 1 0", aerr[1], stall[1]); end
        step();
        checks++; if (rww[1] !== 1'b0 || aluw[1] !== 32'h0) begin errors++; $display("FAIL mis_ld_bubble: got rw=%0h alu=%h expected 0 0", rww[1], aluw[1]); end
        drive(32'h402, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        checks++; if (aerr[1] !== 1'b1) begin errors++; $display("FAIL mis_st_aerr: got %0h expected 1", aerr[1]); end
        step(); step();
        drive(32'h400, 32'h0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1);
        checks++; if (aerr[1] !== 1'b0) begin errors++; $display("FAIL aligned_aerr: got %0h expected 0", aerr[1]); end
        step(); step();
        checks++; if (rdw[1] !== 32'h11223344) begin errors++; $display("FAIL mis_keep400: got %h expected 11223344", rdw[1]); end
        drive(32'h404, 32'h0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1);
        step(); step();
        checks++; if (rdw[1] !== 32'h55667788) begin errors++; $display("FAIL mis_keep404: got %h expected 55667788", rdw[1]); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(32'h404, 32'hA5A5A5A5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        step(); step();
        drive(32'h004, 32'h0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
        step(); step();
        checks++; if (rdw[1] !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap_load: got %h expected a5a5a5a5", rdw[1]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(32'h20, 32'h11111111, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        repeat (3) step();
        drive(32'h20, 32'h22222222, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        step();
        checks++; if (stall[2] !== 1'b1) begin errors++; $display("FAIL mid_stall_wait: got %0h expected 1", stall[2]); end
        rst_n = 1'b0;
        #1;
        checks++; if (stall[2] !== 1'b0) begin errors++; $display("FAIL mid_rst_stall: got %0h expected 0", stall[2]); end
        checks++; if ({rdw[2], aluw[2], insw[2], m2rw[2], rww[2]} !== 71'h0) begin
            errors++; $display("FAIL mid_rst_wb: got rd=%h alu=%h ins=%0d rw=%0h expected all 0", rdw[2], aluw[2], insw[2], rww[2]);
        end
        step();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        drive(32'h20, 32'h0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
        repeat (3) step();
        checks++; if (rdw[2] !== 32'h11111111) begin errors++; $display("FAIL mid_rst_keep: got %h expected 11111111", rdw[2]); end
    endtask

    initial begin
        rst_n = 1'b0;
        alu = '0; wd = '0; ins = '0; mr = 1'b0; mw = 1'b0; m2r = 1'b0; rw = 1'b0;
        test_reset();
        test_alu_op();
        test_store_load();
        test_latency1();
        test_latency4();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs in the 5-stage MIPS pipeline.
- Performs multi-cycle word accesses to an internal data memory.
- Asserts a stall to freeze IF/ID/EX and the EX/MEM register while an access is in flight.
- Drives the MEM/WB register outputs: read data, pass-through ALU result, destination register and WB control.

Parameters:
- DEPTH, 256, data memory size in 32-bit words; power of two, >= 2.
- LATENCY, 2, cycles an instruction occupies MEM for a load or store; >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- aluResultMEM  in  32  byte address for loads/stores; pass-through value otherwise.
- regReadData2MEM  in  32  store data.
- instructionMEM  in  5  destination register number.
- memReadMEM  in  1  load request.
- memWriteMEM  in  1  store request.
- memtoRegMEM  in  1  WB mux select, passed through.
- regWriteMEM  in  1  register write enable, passed through.
- stallMEM  out  1  combinational; high = upstream must hold state.
- alignErrMEM  out  1  combinational; high = misaligned access this cycle.
- memReadDataWB  out  32  registered load data.
- aluResultWB  out  32  registered ALU result.
- instructionWB  out  5  registered destination register.
- memtoRegWB  out  1  registered.
- regWriteWB  out  1  registered.

Behaviour:
- Access definition:
  - access = (memReadMEM | memWriteMEM) & (aluResultMEM[1:0] == 0).
  - If both memReadMEM and memWriteMEM are high, the store wins and memReadDataWB is 0.
- Address: word index = aluResultMEM[log2(DEPTH)+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH.
- States: IDLE, WAIT. Counter cnt has width log2(LATENCY)+1.
- IDLE, no access:
  - stallMEM = 0.
  - Next edge: WB regs load the inputs; memReadDataWB = 0.
- IDLE, access, LATENCY = 1:
  - stallMEM = 0.
  - Next edge commits the access: store writes the array, or load captures the array word into memReadDataWB. WB regs load the inputs.
- IDLE, access, LATENCY > 1:
  - stallMEM = 1.
  - Next edge: go to WAIT with cnt = 1; WB regs load a bubble (all fields 0).
- WAIT:
  - stallMEM = (cnt < LATENCY-1).
  - Inputs are held stable by upstream and are not re-sampled for a new access.
  - If cnt == LATENCY-1, the edge commits exactly as in the LATENCY = 1 case, then returns to IDLE.
  - Otherwise cnt++ and WB regs load a bubble.
- Timing: a load/store spends exactly LATENCY cycles in MEM, and stallMEM is high for LATENCY-1 of them.
- Memory write timing: the array is written exactly once, on the commit edge. Nothing is written before commit.
- Misaligned access (read or write with aluResultMEM[1:0] != 0):
  - alignErrMEM = 1 and stallMEM = 0.
  - No array access is made.
  - Next edge: WB regs load a bubble, so regWriteWB = 0.
  - alignErrMEM is 0 in all other cases.
- Back-to-back accesses: after commit, the next cycle is IDLE and samples new inputs. No dead cycle is inserted.
- Reset (rst_n low, asynchronous):
  - State IDLE, cnt 0.
  - memReadDataWB, aluResultWB, instructionWB, memtoRegWB and regWriteWB all 0.
  - stallMEM and alignErrMEM forced 0 while rst_n is low.
- Reset mid-access: the in-flight access is abandoned and no store is committed. Array contents are not cleared by reset.
- Array read is asynchronous internally. The only visible output of a load is the registered memReadDataWB.

Test Plan:
- Reset, then ALU op (aluResult=0x1234, instr=5'd8, regWrite=1, memtoReg=0) -> next edge: aluResultWB=0x1234, instructionWB=8, regWriteWB=1, memReadDataWB=0, stallMEM never high.
- Store 0xDEADBEEF to 0x10, LATENCY=2 -> stallMEM high for 1 cycle; array word 4 is written on the second edge. Then load 0x10 to r9 -> stall 1 cycle, then memReadDataWB=0xDEADBEEF, instructionWB=9, regWriteWB=1, memtoRegWB=1.
- LATENCY=4: load -> stallMEM high for exactly 3 cycles; WB fields are 0 during the 3 bubbles and the data is valid after the 4th edge.
- Load from 0x13 -> alignErrMEM=1, stallMEM=0, next edge regWriteWB=0. Store to 0x402 -> array unchanged (read back 0x400 and 0x404 unchanged).
- DEPTH=256: store 0xA5A5A5A5 to 0x404 -> load 0x004 returns 0xA5A5A5A5 (wrap-around).
- Store to 0x20 with rst_n pulsed low in the WAIT state (LATENCY=3) -> all WB outputs 0 immediately and stallMEM=0; a later load of 0x20 returns the prior contents.
